// File: rtl/io_map_pkg.sv
// io_map_pkg: shared IO register map for the memory-mapped peripherals.
//   - one-hot word-address select bits for each register
//   - bit positions inside the UART status word
//   - UART shifter state encoding
package io_map_pkg;
   localparam int IO_LEDS_BIT        = 2;
   localparam int IO_UART_DATA_BIT   = 3;
   localparam int IO_UART_STATUS_BIT = 4;

   localparam int ST_BUSY      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_FULL      = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;
endpackage

// File: rtl/io_uart_leds_if.sv
// io_uart_leds_if: the core's IO port (memory-stage IO_mem_* signals).
//   master (core): drives addr / wdata / wr, samples rdata
//   slave (peripheral): consumes addr / wdata / wr, returns rdata combinationally
interface io_uart_leds_if;
   logic [31:0] IO_mem_addr;
   logic [31:0] IO_mem_wdata;
   logic        IO_mem_wr;
   logic [31:0] IO_mem_rdata;

   modport master (output IO_mem_addr, output IO_mem_wdata, output IO_mem_wr,
                   input  IO_mem_rdata);
   modport slave  (input  IO_mem_addr, input  IO_mem_wdata, input  IO_mem_wr,
                   output IO_mem_rdata);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
//   clk, reset  : clock, async active-high reset (flushes pointers/count)
//   push, din   : write request; accepted when not full or when popping
//   pop, dout   : read request (ignored when empty); dout is the head entry
//   count       : occupancy 0..DEPTH; full / empty flags derived from it
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/io_uart_leds.sv
// io_uart_leds: IO peripheral with an LED register and a buffered 8N1 UART TX.
//   clk, reset : system clock, async active-high reset
//   bus        : core IO port (slave); reads are combinational, writes on wr
//   tx         : UART serial output, idle high (registered)
//   leds       : LED register (registered)
// Registers are picked by one-hot word-address bits (see io_map_pkg).
module io_uart_leds
   import io_map_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 27000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 16,
   parameter int LED_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   io_uart_leds_if.slave    bus,
   output logic             tx,
   output logic [LED_W-1:0] leds
);
   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int BW  = $clog2(DIV);
   localparam int CW  = $clog2(FIFO_DEPTH+1);

   logic          sel_leds, sel_data, sel_stat;
   logic          push, pop, clr_ovf, ovf;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status, rdata;

   uart_state_t   state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   // Only a few address/data bits are decoded; the rest are don't-care.
   logic unused_ok;
   assign unused_ok = ^{bus.IO_mem_addr, bus.IO_mem_wdata};

   assign sel_leds = bus.IO_mem_addr[IO_LEDS_BIT];
   assign sel_data = bus.IO_mem_addr[IO_UART_DATA_BIT];
   assign sel_stat = bus.IO_mem_addr[IO_UART_STATUS_BIT];

   assign push    = bus.IO_mem_wr && sel_data;
   assign clr_ovf = bus.IO_mem_wr && sel_stat && bus.IO_mem_wdata[2];

   // Pop when idle, or at the last cycle of a stop bit so frames chain
   // back-to-back with no idle gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && (baud_cnt == '0)));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.IO_mem_wdata[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status                         = '0;
      status[ST_BUSY]                = !fifo_empty || (state != IDLE);
      status[ST_EMPTY]               = fifo_empty;
      status[ST_OVF]                 = ovf;
      status[ST_COUNT_LSB +: 5]      = 5'(fifo_count);
      status[ST_FULL]                = fifo_full;
   end

   // Multiple selects OR together; UART_DATA reads as zero.
   always_comb begin
      rdata = '0;
      if (sel_leds) rdata = rdata | 32'(leds);
      if (sel_stat) rdata = rdata | status;
   end
   assign bus.IO_mem_rdata = rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds <= '0;
         ovf  <= 1'b0;
      end else begin
         if (bus.IO_mem_wr && sel_leds) leds <= bus.IO_mem_wdata[LED_W-1:0];
         // A dropped byte in the same cycle as a clear keeps the flag set.
         if (push && fifo_full && !pop) ovf <= 1'b1;
         else if (clr_ovf)              ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg    <= fifo_dout;
                  tx       <= 1'b0;
                  baud_cnt <= BW'(DIV-1);
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt == '0) begin
                  tx       <= shreg[0];
                  shreg    <= shreg >> 1;
                  bit_idx  <= '0;
                  baud_cnt <= BW'(DIV-1);
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BW'(DIV-1);
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            STOP: begin
               if (baud_cnt == '0) begin
                  if (pop) begin
                     shreg    <= fifo_dout;
                     tx       <= 1'b0;
                     baud_cnt <= BW'(DIV-1);
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_io_uart_leds.sv
module tb_io_uart_leds;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx;
  logic [4:0] leds;

  io_uart_leds_if bus();

  io_uart_leds #(
    .CLK_FREQ_HZ (1000000),
    .BAUD        (100000),
    .FIFO_DEPTH  (16),
    .LED_W       (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  typedef enum {K_RD, K_TX, K_LEDS} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] A_LEDS = 32'h0040_0004;
  localparam logic [31:0] A_DATA = 32'h0040_0008;
  localparam logic [31:0] A_STAT = 32'h0040_0010;

  logic [7:0] b2b [3] = '{8'hA5, 8'h3C, 8'hFF};

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = sb.pop_front();
      case (c.kind)
        K_RD:    act = bus.IO_mem_rdata;
        K_TX:    act = {31'b0, tx};
        default: act = {27'b0, leds};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bn;
    bn = k / 10;
    if (bn == 0) return 1'b0;
    if (bn == 9) return 1'b1;
    return b[bn-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input logic [31:0] act, input logic [31:0] e, input string n);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string n);
    int cyc;
    bus.IO_mem_addr = A_STAT;
    #1;
    cyc = 0;
    while (bus.IO_mem_rdata[0] === 1'b1 && cyc < max_cycles) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus.IO_mem_rdata[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles", n, max_cycles);
    end
  endtask

  task automatic expect_val(input kind_t k, input logic [31:0] e, input string n);
    sb.push_back('{k, e, n});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    bus.IO_mem_addr = a;
    expect_val(K_RD, e, n);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IO_mem_addr  = a;
    bus.IO_mem_wdata = d;
    bus.IO_mem_wr    = 1'b1;
    tick();
    bus.IO_mem_wr    = 1'b0;
  endtask

  initial begin
    bus.IO_mem_addr  = '0;
    bus.IO_mem_wdata = '0;
    bus.IO_mem_wr    = 1'b0;
    tick();
    tick();

    chk_now({31'b0, tx}, 32'd1, "rst_tx_now");
    chk_now({27'b0, leds}, 32'd0, "rst_leds_now");
    expect_val(K_TX, 32'd1, "rst_tx");
    expect_val(K_LEDS, 32'd0, "rst_leds");
    rd(A_STAT, 32'h002, "rst_status");
    reset = 1'b0;
    tick();

    wr(A_LEDS, 32'h15);
    expect_val(K_LEDS, 32'h15, "leds_val");
    rd(A_LEDS, 32'h15, "leds_rd");
    rd(32'h0040_0000, 32'h0, "nosel_rd");
    rd(A_DATA, 32'h0, "data_rd");
    rd(32'h0040_0014, 32'h17, "multi_rd");
    wr(32'h0040_0000, 32'h0A);
    expect_val(K_LEDS, 32'h15, "nosel_wr");
    tick();

    wr(A_DATA, 32'h55);
    rd(A_STAT, 32'h011, "queued_status");
    for (int k = 0; k < 100; k++) begin
      expect_val(K_TX, {31'b0, exp_tx(8'h55, k)}, "tx55");
      if (k == 50) begin
        bus.IO_mem_addr = A_STAT;
        expect_val(K_RD, 32'h003, "busy_status");
      end
      tick();
    end
    expect_val(K_TX, 32'd1, "tx55_idle");
    rd(A_STAT, 32'h002, "done_status");

    for (int i = 0; i < 17; i++) wr(A_DATA, i);
    rd(A_STAT, 32'h301, "full_no_ovf");
    for (int i = 0; i < 16; i++) wr(A_DATA, 32'hA0 + i);
    rd(A_STAT, 32'h305, "ovf_set");
    wr(32'h0040_0018, 32'h4);
    rd(A_STAT, 32'h305, "ovf_set_wins");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h301, "ovf_clr");

    expect_val(K_TX, 32'd0, "pre_rst_tx");
    tick();
    reset = 1'b1;
    #1;
    chk_now({31'b0, tx}, 32'd1, "midrst_tx_async");
    expect_val(K_TX, 32'd1, "midrst_tx");
    expect_val(K_LEDS, 32'd0, "midrst_leds");
    rd(A_STAT, 32'h002, "midrst_status");
    reset = 1'b0;
    tick();

    bus.IO_mem_addr  = A_DATA;
    bus.IO_mem_wr    = 1'b1;
    bus.IO_mem_wdata = {24'b0, b2b[0]};
    tick();
    bus.IO_mem_wdata = {24'b0, b2b[1]};
    tick();
    for (int k = 0; k < 300; k++) begin
      if (k == 0) bus.IO_mem_wdata = {24'b0, b2b[2]};
      else        bus.IO_mem_wr = 1'b0;
      expect_val(K_TX, {31'b0, exp_tx(b2b[k/100], k % 100)}, "b2b_tx");
      tick();
    end
    expect_val(K_TX, 32'd1, "b2b_idle_tx");
    rd(A_STAT, 32'h002, "b2b_idle_status");
    wait_idle(20, "b2b_wait_idle");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
